// File: rtl/alu_share_ctrl.sv
// Round-robin controller that time-shares one combinational ALU between a fetch
// requester (0) and an execute requester (1); one operation in flight at a time.
module alu_share_ctrl #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned SEL_W   = 3,
   parameter bit          RR_INIT = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_0,
   input  logic              req_valid_1,
   output logic              req_ready_0,
   output logic              req_ready_1,
   input  logic [SEL_W-1:0]  req_op_0,
   input  logic [SEL_W-1:0]  req_op_1,
   input  logic [DATA_W-1:0] req_a_0,
   input  logic [DATA_W-1:0] req_a_1,
   input  logic [DATA_W-1:0] req_b_0,
   input  logic [DATA_W-1:0] req_b_1,
   output logic              rsp_valid_0,
   output logic              rsp_valid_1,
   input  logic              rsp_ready_0,
   input  logic              rsp_ready_1,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_zero,
   output logic              rsp_carry,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [SEL_W-1:0]  alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_zero,
   input  logic              alu_carry,
   output logic              busy,
   output logic              grant_id,
   output logic [15:0]       op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t              state_q, state_d;
   logic                prio_q, prio_d;
   logic                grant_q, grant_d;
   logic [DATA_W-1:0]   alu_a_q, alu_a_d;
   logic [DATA_W-1:0]   alu_b_q, alu_b_d;
   logic [SEL_W-1:0]    alu_sel_q, alu_sel_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_zero_q, rsp_zero_d;
   logic                rsp_carry_q, rsp_carry_d;
   logic [15:0]         op_count_q, op_count_d;
   logic                gnt_0, gnt_1;
   logic                pick;

   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      grant_d     = grant_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_sel_d   = alu_sel_q;
      rsp_data_d  = rsp_data_q;
      rsp_zero_d  = rsp_zero_q;
      rsp_carry_d = rsp_carry_q;
      op_count_d  = op_count_q;
      gnt_0       = 1'b0;
      gnt_1       = 1'b0;
      pick        = grant_q;
      case (state_q)
         IDLE: begin
            if (req_valid_0 || req_valid_1) begin
               // Priority pointer only matters when both requesters contend.
               pick      = (req_valid_0 && req_valid_1) ? prio_q : req_valid_1;
               gnt_0     = ~pick;
               gnt_1     = pick;
               grant_d   = pick;
               alu_sel_d = pick ? req_op_1 : req_op_0;
               alu_a_d   = pick ? req_a_1  : req_a_0;
               alu_b_d   = pick ? req_b_1  : req_b_0;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            rsp_data_d  = alu_out;
            rsp_zero_d  = alu_zero;
            rsp_carry_d = alu_carry;
            state_d     = RESP;
         end
         RESP: begin
            if (grant_q ? rsp_ready_1 : rsp_ready_0) begin
               op_count_d = op_count_q + 16'd1;
               prio_d     = ~grant_q;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         prio_q      <= RR_INIT;
         grant_q     <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         rsp_data_q  <= '0;
         rsp_zero_q  <= 1'b0;
         rsp_carry_q <= 1'b0;
         op_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         grant_q     <= grant_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sel_q   <= alu_sel_d;
         rsp_data_q  <= rsp_data_d;
         rsp_zero_q  <= rsp_zero_d;
         rsp_carry_q <= rsp_carry_d;
         op_count_q  <= op_count_d;
      end
   end

   // Ready is held low while reset is asserted even though the state reads IDLE.
   assign req_ready_0 = gnt_0 & rst_n;
   assign req_ready_1 = gnt_1 & rst_n;
   assign rsp_valid_0 = (state_q == RESP) && !grant_q;
   assign rsp_valid_1 = (state_q == RESP) &&  grant_q;
   assign busy        = (state_q != IDLE);
   assign grant_id    = grant_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_sel     = alu_sel_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_zero    = rsp_zero_q;
   assign rsp_carry   = rsp_carry_q;
   assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: drives a behavioural ALU and checks arbitration, latency,
// back-pressure, reset and counter wrap against a transaction-level reference model.
module tb_alu_share_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
   logic        req_ready_0, req_ready_1;
   logic [2:0]  req_op_0 = '0, req_op_1 = '0;
   logic [15:0] req_a_0 = '0, req_a_1 = '0, req_b_0 = '0, req_b_1 = '0;
   logic        rsp_valid_0, rsp_valid_1;
   logic        rsp_ready_0 = 1'b0, rsp_ready_1 = 1'b0;
   logic [15:0] rsp_data;
   logic        rsp_zero, rsp_carry;
   logic [15:0] alu_a, alu_b, alu_out;
   logic [2:0]  alu_sel;
   logic        alu_zero, alu_carry;
   logic        busy, grant_id;
   logic [15:0] op_count;
   logic [16:0] alu_res;

   int          checks = 0;
   int          errors = 0;
   bit          mprio;
   logic [15:0] mcount;

   alu_share_ctrl #(.DATA_W(16), .SEL_W(3), .RR_INIT(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
      .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
      .req_op_0(req_op_0), .req_op_1(req_op_1),
      .req_a_0(req_a_0), .req_a_1(req_a_1),
      .req_b_0(req_b_0), .req_b_1(req_b_1),
      .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
      .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
      .busy(busy), .grant_id(grant_id), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Reference ALU: returns {carry, result}; carry on subtract means borrow.
   function automatic logic [16:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
      int unsigned ua = a;
      int unsigned ub = b;
      case (op)
         3'd0: return 17'(ua + ub);
         3'd1: return {(ua < ub), 16'(ua - ub)};
         3'd2: return {1'b0, a & b};
         3'd3: return {1'b0, a ^ b};
         3'd4: return {a[15], a << 1};
         3'd5: return {a[0], a >> 1};
         3'd6: return {1'b0, a | b};
         default: return {16'd0, ($signed(a) < $signed(b))};
      endcase
   endfunction

   assign alu_res   = ref_alu(alu_sel, alu_a, alu_b);
   assign alu_out   = alu_res[15:0];
   assign alu_carry = alu_res[16];
   assign alu_zero  = (alu_out == 16'd0);

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid_0 = 1'b0; req_valid_1 = 1'b0; rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      mprio = 1'b0;
      mcount = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid_0 = 1'b1; req_valid_1 = 1'b1;
      #1;
      checks++; if ({req_ready_1, req_ready_0} !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b exp 00", {req_ready_1, req_ready_0}); end
      checks++; if ({rsp_valid_1, rsp_valid_0, busy, grant_id} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b exp 0000", {rsp_valid_1, rsp_valid_0, busy, grant_id}); end
      checks++; if ({alu_a, alu_b, alu_sel} !== 35'd0) begin errors++; $display("FAIL reset_alu_regs: got %h exp 0", {alu_a, alu_b, alu_sel}); end
      checks++; if ({rsp_data, rsp_zero, rsp_carry, op_count} !== 34'd0) begin errors++; $display("FAIL reset_rsp: got %h exp 0", {rsp_data, rsp_zero, rsp_carry, op_count}); end
      @(negedge clk);
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      rst_n = 1'b1;
      mprio = 1'b0;
      mcount = '0;
   endtask

   task automatic test_single();
      @(negedge clk);
      req_valid_0 = 1'b1; req_op_0 = 3'd0; req_a_0 = 16'h0003; req_b_0 = 16'h0004; rsp_ready_0 = 1'b1;
      #1;
      checks++; if ({req_ready_1, req_ready_0} !== 2'b01) begin errors++; $display("FAIL single_accept: got %b exp 01", {req_ready_1, req_ready_0}); end
      @(negedge clk);
      req_valid_0 = 1'b0;
      checks++; if ({busy, rsp_valid_0, grant_id} !== 3'b100) begin errors++; $display("FAIL single_exec: got %b exp 100", {busy, rsp_valid_0, grant_id}); end
      checks++; if ({alu_sel, alu_a, alu_b} !== {3'd0, 16'h0003, 16'h0004}) begin errors++; $display("FAIL single_operands: got %h exp %h", {alu_sel, alu_a, alu_b}, {3'd0, 16'h0003, 16'h0004}); end
      @(negedge clk);
      checks++; if ({rsp_valid_1, rsp_valid_0} !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b exp 01", {rsp_valid_1, rsp_valid_0}); end
      checks++; if ({rsp_data, rsp_zero} !== {16'h0007, 1'b0}) begin errors++; $display("FAIL single_data: got %h/%b exp 0007/0", rsp_data, rsp_zero); end
      @(negedge clk);
      rsp_ready_0 = 1'b0;
      mcount++;
      mprio = 1'b1;
      checks++; if ({busy, rsp_valid_0} !== 2'b00) begin errors++; $display("FAIL single_done: got %b exp 00", {busy, rsp_valid_0}); end
      checks++; if (op_count !== mcount) begin errors++; $display("FAIL single_count: got %h exp %h", op_count, mcount); end
   endtask

   task automatic test_priority();
      apply_reset();
      @(negedge clk);
      req_valid_1 = 1'b1; req_op_1 = 3'd1; req_a_1 = 16'd5; req_b_1 = 16'd5;
      req_valid_0 = 1'b1; req_op_0 = 3'd6; req_a_0 = 16'h00F0; req_b_0 = 16'h000F;
      rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
      #1;
      checks++; if ({req_ready_1, req_ready_0} !== 2'b01) begin errors++; $display("FAIL prio_first_grant: got %b exp 01", {req_ready_1, req_ready_0}); end
      @(negedge clk);
      req_valid_0 = 1'b0;
      checks++; if ({grant_id, req_ready_1} !== 2'b00) begin errors++; $display("FAIL prio_exec0: got %b exp 00", {grant_id, req_ready_1}); end
      @(negedge clk);
      checks++; if ({rsp_valid_1, rsp_valid_0, rsp_data, rsp_zero} !== {2'b01, 16'h00FF, 1'b0}) begin errors++; $display("FAIL prio_rsp0: got %b %h %b exp 01 00ff 0", {rsp_valid_1, rsp_valid_0}, rsp_data, rsp_zero); end
      @(negedge clk);
      checks++; if ({req_ready_1, req_ready_0} !== 2'b10) begin errors++; $display("FAIL prio_second_grant: got %b exp 10", {req_ready_1, req_ready_0}); end
      @(negedge clk);
      req_valid_1 = 1'b0;
      @(negedge clk);
      checks++; if ({rsp_valid_1, rsp_valid_0, rsp_data, rsp_zero} !== {2'b10, 16'h0000, 1'b1}) begin errors++; $display("FAIL prio_rsp1: got %b %h %b exp 10 0000 1", {rsp_valid_1, rsp_valid_0}, rsp_data, rsp_zero); end
      @(negedge clk);
      rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
      mcount = 16'd2;
      mprio = 1'b0;
      checks++; if (op_count !== mcount) begin errors++; $display("FAIL prio_count: got %h exp %h", op_count, mcount); end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  op [2];
      logic [15:0] a [2];
      logic [15:0] b [2];
      bit          regen [2];
      bit          exp_g = 1'b0;
      logic [16:0] exp_r = '0;
      int          done = 0;
      bit          grants [$];
      apply_reset();
      regen[0] = 1'b1; regen[1] = 1'b1;
      rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
      for (int cyc = 0; cyc < 60 && done < 6; cyc++) begin
         @(negedge clk);
         if (rsp_valid_0 || rsp_valid_1) begin
            checks++; if ({rsp_valid_1, rsp_valid_0} !== (exp_g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_rsp_port: got %b exp grant %0d", {rsp_valid_1, rsp_valid_0}, exp_g); end
            checks++; if ({rsp_carry, rsp_data} !== exp_r) begin errors++; $display("FAIL b2b_data: got %h exp %h", {rsp_carry, rsp_data}, exp_r); end
            done++;
            mcount++;
            mprio = ~exp_g;
         end
         for (int p = 0; p < 2; p++) begin
            if (regen[p]) begin
               op[p] = 3'($urandom); a[p] = 16'($urandom); b[p] = 16'($urandom); regen[p] = 1'b0;
            end
         end
         req_op_0 = op[0]; req_a_0 = a[0]; req_b_0 = b[0];
         req_op_1 = op[1]; req_a_1 = a[1]; req_b_1 = b[1];
         req_valid_0 = (done < 6); req_valid_1 = (done < 6);
         #1;
         if (req_ready_0 || req_ready_1) begin
            checks++; if ({req_ready_1, req_ready_0} !== {mprio, ~mprio}) begin errors++; $display("FAIL b2b_grant: got %b exp %b", {req_ready_1, req_ready_0}, {mprio, ~mprio}); end
            exp_g = mprio;
            exp_r = ref_alu(op[exp_g], a[exp_g], b[exp_g]);
            grants.push_back(exp_g);
            regen[exp_g] = 1'b1;
         end
      end
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      @(negedge clk);
      rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
      checks++; if (done != 6) begin errors++; $display("FAIL b2b_timeout: got %0d ops exp 6", done); end
      checks++; if (op_count !== 16'd6) begin errors++; $display("FAIL b2b_count: got %h exp 0006", op_count); end
      foreach (grants[i]) begin
         checks++; if (grants[i] != bit'(i % 2)) begin errors++; $display("FAIL b2b_alternate: op %0d got %0d exp %0d", i, grants[i], i % 2); end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid_0 = 1'b1; req_op_0 = 3'($urandom); req_a_0 = 16'($urandom) | 16'h1; req_b_0 = 16'($urandom);
      @(negedge clk);
      req_valid_0 = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if ({busy, grant_id, rsp_valid_0, rsp_valid_1} !== 4'b0000) begin errors++; $display("FAIL midreset_ctrl: got %b exp 0000", {busy, grant_id, rsp_valid_0, rsp_valid_1}); end
      checks++; if ({alu_a, alu_b, alu_sel, op_count, rsp_data} !== 67'd0) begin errors++; $display("FAIL midreset_regs: got %h exp 0", {alu_a, alu_b, alu_sel, op_count, rsp_data}); end
      @(negedge clk);
      rst_n = 1'b1;
      mprio = 1'b0;
      mcount = '0;
      repeat (4) begin
         @(negedge clk);
         checks++; if ({rsp_valid_1, rsp_valid_0, busy} !== 3'b000) begin errors++; $display("FAIL midreset_no_rsp: got %b exp 000", {rsp_valid_1, rsp_valid_0, busy}); end
      end
      test_single();
   endtask

   task automatic test_backpressure();
      logic [16:0] exp_r;
      @(negedge clk);
      req_valid_1 = 1'b1; req_op_1 = 3'($urandom); req_a_1 = 16'($urandom); req_b_1 = 16'($urandom);
      rsp_ready_1 = 1'b0; rsp_ready_0 = 1'b1;
      exp_r = ref_alu(req_op_1, req_a_1, req_b_1);
      @(negedge clk);
      req_valid_1 = 1'b0; req_valid_0 = 1'b1;
      #1;
      checks++; if (req_ready_0 !== 1'b0) begin errors++; $display("FAIL bp_exec_ready0: got %b exp 0", req_ready_0); end
      repeat (5) begin
         @(negedge clk);
         checks++; if ({rsp_valid_1, rsp_valid_0, busy, req_ready_0} !== 4'b1010) begin errors++; $display("FAIL bp_hold_ctrl: got %b exp 1010", {rsp_valid_1, rsp_valid_0, busy, req_ready_0}); end
         checks++; if ({rsp_carry, rsp_data} !== exp_r || rsp_zero !== (exp_r[15:0] == 16'd0)) begin errors++; $display("FAIL bp_hold_data: got %h exp %h", {rsp_carry, rsp_data}, exp_r); end
      end
      req_valid_0 = 1'b0;
      rsp_ready_1 = 1'b1;
      @(negedge clk);
      rsp_ready_1 = 1'b0; rsp_ready_0 = 1'b0;
      mcount++;
      mprio = 1'b0;
      checks++; if ({rsp_valid_1, busy} !== 2'b00 || op_count !== mcount) begin errors++; $display("FAIL bp_release: got %b cnt %h exp 00 cnt %h", {rsp_valid_1, busy}, op_count, mcount); end
   endtask

   task automatic test_random();
      logic [1:0]  v;
      bit          g;
      logic [16:0] exp_r;
      logic [34:0] exp_ops;
      int unsigned d;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         v = 2'($urandom_range(1, 3));
         req_valid_0 = v[0]; req_valid_1 = v[1];
         req_op_0 = 3'($urandom); req_a_0 = 16'($urandom); req_b_0 = 16'($urandom);
         req_op_1 = 3'($urandom); req_a_1 = 16'($urandom); req_b_1 = 16'($urandom);
         if (t % 4 == 0) req_b_0 = req_a_0;
         g = (v == 2'b11) ? mprio : v[1];
         exp_ops = g ? {req_op_1, req_a_1, req_b_1} : {req_op_0, req_a_0, req_b_0};
         exp_r = ref_alu(exp_ops[34:32], exp_ops[31:16], exp_ops[15:0]);
         #1;
         checks++; if ({req_ready_1, req_ready_0} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd_grant: txn %0d got %b exp grant %0d", t, {req_ready_1, req_ready_0}, g); end
         @(negedge clk);
         req_valid_0 = 1'b0; req_valid_1 = 1'b0;
         checks++; if ({grant_id, alu_sel, alu_a, alu_b} !== {g, exp_ops}) begin errors++; $display("FAIL rnd_latch: txn %0d got %h exp %h", t, {grant_id, alu_sel, alu_a, alu_b}, {g, exp_ops}); end
         d = $urandom_range(0, 3);
         for (int unsigned k = 0; k <= d; k++) begin
            @(negedge clk);
            checks++; if ({rsp_valid_1, rsp_valid_0} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd_rsp_port: txn %0d got %b exp grant %0d", t, {rsp_valid_1, rsp_valid_0}, g); end
            checks++; if ({rsp_carry, rsp_data} !== exp_r || rsp_zero !== (exp_r[15:0] == 16'd0)) begin errors++; $display("FAIL rnd_data: txn %0d got %h z%b exp %h", t, {rsp_carry, rsp_data}, rsp_zero, exp_r); end
            if (g) begin rsp_ready_1 = (k == d); rsp_ready_0 = 1'($urandom); end
            else   begin rsp_ready_0 = (k == d); rsp_ready_1 = 1'($urandom); end
         end
         @(negedge clk);
         rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
         mcount++;
         mprio = ~g;
         checks++; if ({busy, rsp_valid_1, rsp_valid_0} !== 3'b000 || op_count !== mcount) begin errors++; $display("FAIL rnd_complete: txn %0d got %b cnt %h exp 000 cnt %h", t, {busy, rsp_valid_1, rsp_valid_0}, op_count, mcount); end
      end
   endtask

   // Jumps the counter to its top value instead of running 65535 real operations.
   task automatic test_wrap();
      @(negedge clk);
      force dut.op_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.op_count_q;
      mcount = 16'hFFFF;
      test_single();
      checks++; if (op_count !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %h exp 0000", op_count); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_back_to_back();
      test_reset_mid();
      test_backpressure();
      test_random();
      test_wrap();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
